// File: rtl/screen_sel_ctl.sv
// Screen sequencer for PONG: MENU -> START -> PLAY -> OVER, driven by mouse clicks
// and scores. It muxes the menu and game renderers onto one rgb output and only
// switches source at a frame boundary.
//
//  state | meaning
//  MENU  | menu shown, waiting for a click on the start button
//  START | game logic held in reset until the next frame tick
//  PLAY  | game logic enabled, waiting for a winning score
//  OVER  | game frozen, result shown; returns to MENU on timeout or click
module screen_sel_ctl #(
    parameter int BTN_X0      = 352,
    parameter int BTN_X1      = 447,
    parameter int BTN_Y0      = 280,
    parameter int BTN_Y1      = 319,
    parameter int WIN_SCORE   = 5,
    parameter int OVER_FRAMES = 180
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [3:0]  score_l,
    input  logic [3:0]  score_r,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_menu,
    input  logic [11:0] rgb_game,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        game_rst,
    output logic        game_en,
    output logic [1:0]  winner,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [11:0] X0 = 12'(BTN_X0);
    localparam logic [11:0] X1 = 12'(BTN_X1);
    localparam logic [11:0] Y0 = 12'(BTN_Y0);
    localparam logic [11:0] Y1 = 12'(BTN_Y1);
    localparam logic [3:0]  WIN = 4'(WIN_SCORE);
    localparam logic [7:0]  FRAME_LAST = 8'(OVER_FRAMES - 1);

    state_t      state, state_nxt;
    logic        vblnk_d, ml_d, src_sel;
    logic [7:0]  frame_cnt, frame_cnt_nxt;
    logic [1:0]  winner_q, winner_nxt;
    logic        frame_tick, click, hit, win_l, win_r;

    assign frame_tick = vblnk_in & ~vblnk_d;
    assign click      = mouse_left & ~ml_d;
    assign hit        = (xpos >= X0) && (xpos <= X1) && (ypos >= Y0) && (ypos <= Y1);
    assign win_l      = score_l >= WIN;
    assign win_r      = score_r >= WIN;

    // Next-state, frame counter and winner latch.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        winner_nxt    = winner_q;
        case (state)
            MENU: begin
                if (click && hit) begin
                    state_nxt  = START;
                    winner_nxt = 2'b00;
                end
            end
            START: begin
                if (frame_tick) state_nxt = PLAY;
            end
            PLAY: begin
                if (win_l || win_r) begin
                    state_nxt     = OVER;
                    winner_nxt    = {win_r, win_l};
                    frame_cnt_nxt = 8'd0;
                end
            end
            OVER: begin
                // Saturate instead of wrapping so a long hold can never re-trigger.
                if (frame_tick && frame_cnt != 8'hFF) frame_cnt_nxt = frame_cnt + 8'd1;
                if (click || (frame_tick && frame_cnt == FRAME_LAST)) state_nxt = MENU;
            end
            default: state_nxt = MENU;
        endcase
    end

    // Control registers; source select only moves on a frame tick to avoid tearing.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= MENU;
            frame_cnt <= 8'd0;
            winner_q  <= 2'b00;
            vblnk_d   <= 1'b0;
            ml_d      <= 1'b0;
            src_sel   <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            winner_q  <= winner_nxt;
            vblnk_d   <= vblnk_in;
            ml_d      <= mouse_left;
            if (frame_tick) src_sel <= (state == PLAY) || (state == OVER);
        end
    end

    // One-cycle timing pipeline and pixel mux, blanked outside the active area.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_out <= 11'd0;
            hcount_out <= 11'd0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            vcount_out <= vcount_in;
            hcount_out <= hcount_in;
            vsync_out  <= vsync_in;
            hsync_out  <= hsync_in;
            vblnk_out  <= vblnk_in;
            hblnk_out  <= hblnk_in;
            rgb_out    <= (hblnk_in | vblnk_in) ? 12'd0 : (src_sel ? rgb_game : rgb_menu);
        end
    end

    assign game_rst  = (state == START);
    assign game_en   = (state == PLAY);
    assign state_out = state;
    assign winner    = winner_q;

endmodule

// File: tb/tb_screen_sel_ctl.sv
// Bench for screen_sel_ctl: a compact 16x8 timing raster, directed scenarios for
// the screen flow, then a randomized phase. A reference model predicts every
// output cycle into a queue that a negedge monitor drains and compares.
module tb_screen_sel_ctl;

    localparam int S_MENU = 0, S_START = 1, S_PLAY = 2, S_OVER = 3;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        mouse_left = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic [3:0]  score_l = '0, score_r = '0;
    logic [10:0] vcount_in = '0, hcount_in = '0;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
    logic [11:0] rgb_menu = '0, rgb_game = '0;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        game_rst, game_en;
    logic [1:0]  winner, state_out;

    always #5 pclk = ~pclk;

    screen_sel_ctl dut (
        .pclk(pclk), .rst(rst), .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos),
        .score_l(score_l), .score_r(score_r),
        .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
        .vblnk_in(vblnk_in), .hblnk_in(hblnk_in), .rgb_menu(rgb_menu), .rgb_game(rgb_game),
        .vcount_out(vcount_out), .hcount_out(hcount_out), .vsync_out(vsync_out),
        .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .game_rst(game_rst), .game_en(game_en),
        .winner(winner), .state_out(state_out)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        grst;
        logic        gen;
        logic [1:0]  win;
        logic [11:0] rgb;
        logic [10:0] vc;
        logic [10:0] hc;
        logic        vs, hs, vb, hb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: screen, displayed source, OVER frame count, result.
    int         m_state = S_MENU;
    bit         m_src = 1'b0;
    int         m_cnt = 0;
    logic [1:0] m_win = 2'b00;
    bit         m_vb_prev = 1'b0, m_ml_prev = 1'b0;

    function automatic exp_t model_step();
        exp_t e;
        bit   tick, clk_evt, on_btn, lw, rw, done;
        int   nxt;
        e = '0;
        if (rst) begin
            m_state = S_MENU; m_src = 1'b0; m_cnt = 0; m_win = 2'b00;
            m_vb_prev = 1'b0; m_ml_prev = 1'b0;
            return e;
        end
        tick    = vblnk_in && !m_vb_prev;
        clk_evt = mouse_left && !m_ml_prev;
        on_btn  = (xpos >= 352) && (xpos <= 447) && (ypos >= 280) && (ypos <= 319);
        lw      = (score_l >= 5);
        rw      = (score_r >= 5);
        e.rgb = (hblnk_in || vblnk_in) ? 12'd0 : (m_src ? rgb_game : rgb_menu);
        e.vc = vcount_in; e.hc = hcount_in;
        e.vs = vsync_in;  e.hs = hsync_in; e.vb = vblnk_in; e.hb = hblnk_in;
        if (tick) m_src = (m_state == S_PLAY) || (m_state == S_OVER);
        nxt = m_state;
        if (m_state == S_MENU && clk_evt && on_btn) begin
            nxt = S_START; m_win = 2'b00;
        end else if (m_state == S_START && tick) begin
            nxt = S_PLAY;
        end else if (m_state == S_PLAY && (lw || rw)) begin
            nxt = S_OVER; m_win = {rw, lw}; m_cnt = 0;
        end else if (m_state == S_OVER) begin
            done = clk_evt || (tick && m_cnt == 179);
            if (tick && m_cnt < 255) m_cnt++;
            if (done) nxt = S_MENU;
        end
        m_state   = nxt;
        m_vb_prev = vblnk_in;
        m_ml_prev = mouse_left;
        e.st   = 2'(m_state);
        e.grst = (m_state == S_START);
        e.gen  = (m_state == S_PLAY);
        e.win  = m_win;
        return e;
    endfunction

    // Monitor: every cycle the DUT presents a full output word; compare against the queue head.
    always @(negedge pclk) begin
        exp_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a.st = state_out; a.grst = game_rst; a.gen = game_en; a.win = winner;
            a.rgb = rgb_out; a.vc = vcount_out; a.hc = hcount_out;
            a.vs = vsync_out; a.hs = hsync_out; a.vb = vblnk_out; a.hb = hblnk_out;
            n_checks++;
            if (a !== e) begin
                n_errors++;
                if (n_errors <= 20)
                    $display("FAIL scoreboard t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Raster position of the next cycle to drive, plus facts about the last driven cycle.
    int          h = 0, v = 0;
    logic [11:0] last_menu, last_game;
    bit          last_vis, last_tick;

    task automatic run_cycle();
        exp_t e;
        hcount_in = 11'(h); vcount_in = 11'(v);
        hblnk_in = (h >= 12); vblnk_in = (v >= 6);
        hsync_in = (h == 13); vsync_in = (v == 7);
        rgb_menu = 12'($urandom); rgb_game = 12'($urandom);
        last_menu = rgb_menu; last_game = rgb_game;
        last_vis  = (h < 12) && (v < 6);
        last_tick = (h == 0) && (v == 6);
        e = model_step();
        @(posedge pclk);
        sb_q.push_back(e);
        #1;
        h++;
        if (h == 16) begin
            h = 0; v++;
            if (v == 8) v = 0;
        end
    endtask

    task automatic run_to_tick();
        for (int i = 0; i < 300; i++) begin
            run_cycle();
            if (last_tick) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic run_to_vis();
        for (int i = 0; i < 300; i++) begin
            run_cycle();
            if (last_vis) return;
        end
        chk("vis_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int hh, input int vv);
        for (int i = 0; i < 300; i++) begin
            if (h == hh && v == vv) return;
            run_cycle();
        end
        chk("pos_timeout", 0, 1);
    endtask

    task automatic press(input int x, input int y);
        xpos = 12'(x); ypos = 12'(y); mouse_left = 1'b1;
        run_cycle();
    endtask

    task automatic release_btn();
        mouse_left = 1'b0;
        run_cycle();
    endtask

    initial begin
        // Reset and idle.
        rst = 1'b1;
        repeat (3) run_cycle();
        rst = 1'b0;
        run_to_tick(); run_to_tick();
        chk("idle_state", state_out, 0);
        chk("idle_game_en", game_en, 0);
        run_to_vis();
        chk("idle_rgb_menu", rgb_out, last_menu);

        // Near misses: left of button, below button, held button sliding on.
        wait_pos(2, 1);
        press(351, 280); chk("miss_x_state", state_out, 0); release_btn();
        press(400, 320); chk("miss_y_state", state_out, 0); release_btn();
        xpos = 12'd0; ypos = 12'd0; mouse_left = 1'b1; run_cycle();
        xpos = 12'd400; ypos = 12'd300; repeat (5) run_cycle();
        chk("held_state", state_out, 0);
        release_btn();

        // Start from the top-left corner of the button.
        wait_pos(4, 2);
        press(352, 280);
        chk("start_state", state_out, 1);
        chk("start_game_rst", game_rst, 1);
        release_btn();
        run_to_tick();
        chk("play_state", state_out, 2);
        chk("play_game_en", game_en, 1);
        run_to_vis();
        chk("play_first_frame_menu", rgb_out, last_menu);
        run_to_tick(); run_to_vis();
        chk("play_rgb_game", rgb_out, last_game);

        // Draw, then the full OVER timeout.
        score_l = 4'd5; score_r = 4'd5; run_cycle();
        chk("draw_state", state_out, 3);
        chk("draw_winner", winner, 3);
        chk("draw_game_en", game_en, 0);
        score_l = 4'd0; score_r = 4'd0;
        repeat (179) run_to_tick();
        chk("over_179_state", state_out, 3);
        run_to_tick();
        chk("over_180_state", state_out, 0);
        chk("menu_winner_held", winner, 3);

        // Right win, early exit by click; bottom-right corner starts the game.
        wait_pos(5, 1);
        press(447, 319);
        chk("corner_start_state", state_out, 1);
        chk("winner_cleared", winner, 0);
        release_btn();
        run_to_tick();
        score_r = 4'd5; run_cycle();
        chk("rwin_state", state_out, 3);
        chk("rwin_winner", winner, 2);
        score_r = 4'd0;
        repeat (10) run_to_tick();
        repeat (5) run_cycle();
        press(0, 0);
        chk("early_exit_state", state_out, 0);
        chk("early_exit_winner", winner, 2);
        release_btn();
        run_to_vis();
        chk("menu_before_tick_game", rgb_out, last_game);
        run_to_tick(); run_to_vis();
        chk("menu_after_tick", rgb_out, last_menu);

        // Reset pulse mid-line while playing.
        wait_pos(5, 1);
        press(400, 300); release_btn();
        run_to_tick(); run_to_tick();
        wait_pos(3, 2);
        rst = 1'b1; run_cycle();
        chk("rst_state", state_out, 0);
        chk("rst_game_en", game_en, 0);
        chk("rst_rgb", rgb_out, 0);
        rst = 1'b0; run_cycle();
        chk("rst_then_menu", rgb_out, last_menu);

        // Randomized phase: scoreboard checks every cycle.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 25) == 0) mouse_left = ~mouse_left;
            if ($urandom_range(0, 7) == 0) begin
                xpos = 12'($urandom_range(340, 460));
                ypos = 12'($urandom_range(270, 330));
            end
            if ($urandom_range(0, 150) == 0) begin
                score_l = 4'($urandom_range(0, 15));
                score_r = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 40) == 0) begin
                score_l = 4'd0; score_r = 4'd0;
            end
            rst = ($urandom_range(0, 1500) == 0);
            run_cycle();
        end
        rst = 1'b0;
        repeat (3) run_cycle();
        @(negedge pclk); #1;
        chk("queue_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
